// File: rtl/scan_pkg.sv
// Shared definitions for the scan master: remote-state encodings, command op
// codes and the controller state type.
package scan_pkg;

    localparam logic [3:0] RS = 4'b0001;
    localparam logic [3:0] RI = 4'b0010;
    localparam logic [3:0] SH = 4'b0100;
    localparam logic [3:0] UP = 4'b1000;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;
    localparam logic [1:0] OP_RESET = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TO_RI,
        S_ENTER,
        S_SHIFT,
        S_EXIT,
        S_WAIT,
        S_RST_PATH,
        S_DONE
    } ctrl_e;

endpackage

// File: rtl/scan_mirror.sv
// Next-state function of the remote 4-state FSM. Purely combinational; the
// caller owns the state register.
module scan_mirror
    import scan_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       x_i,
    output logic [3:0] next_o
);

    always_comb begin
        next_o = RS;
        case (state_i)
            RS: next_o = x_i ? RS : RI;
            RI: next_o = x_i ? SH : RI;
            SH: next_o = x_i ? SH : UP;
            UP: next_o = x_i ? RS : RI;
            default: next_o = RS;
        endcase
    end

endmodule

// File: rtl/scan_master.sv
// Turns IDLE/SHIFT/RESET commands into the cycle-exact mode-line sequence for
// the remote FSM, keeping a registered mirror of the remote state.
module scan_master
    import scan_pkg::*;
#(
    parameter int W     = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rs_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [W-1:0]     cmd_data,
    output logic             x,
    output logic             sdo,
    input  logic             sdi,
    output logic             rsp_valid,
    output logic [W-1:0]     rsp_data,
    output logic [3:0]       mstate
);

    localparam logic [LEN_W-1:0] W_LEN = LEN_W'(W);

    ctrl_e            state_q;
    logic [3:0]       mstate_q, mstate_d;
    logic             x_q, sdo_q, rdy_q, rv_q;
    logic [W-1:0]     rd_q, data_q, cap_q;
    logic [LEN_W-1:0] cnt_q, idx_q;
    logic [1:0]       op_q;

    logic             accept, need_ri, from_q, dsp_en;
    logic [LEN_W-1:0] len_c, d_len;
    logic [1:0]       d_op;
    logic [W-1:0]     d_data;

    scan_mirror u_mirror (
        .state_i(mstate_q),
        .x_i    (x_q),
        .next_o (mstate_d)
    );

    assign len_c   = (cmd_len > W_LEN) ? W_LEN : cmd_len;
    assign accept  = cmd_valid && rdy_q;
    // Work that needs RI first parks one cycle in TO_RI, then dispatches from the latched copy.
    assign need_ri = (mstate_q == RS) && ((cmd_op == OP_IDLE) || (cmd_op == OP_SHIFT));
    assign from_q  = (state_q == S_TO_RI);
    assign dsp_en  = from_q || (accept && !need_ri);
    assign d_op    = from_q ? op_q   : cmd_op;
    assign d_len   = from_q ? cnt_q  : len_c;
    assign d_data  = from_q ? data_q : cmd_data;

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            state_q  <= S_IDLE;
            mstate_q <= RS;
            x_q      <= 1'b1;
            sdo_q    <= 1'b0;
            rdy_q    <= 1'b1;
            rv_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            cap_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            op_q     <= OP_IDLE;
        end else begin
            mstate_q <= mstate_d;
            rv_q     <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (accept) begin
                        rdy_q  <= 1'b0;
                        op_q   <= cmd_op;
                        cnt_q  <= len_c;
                        data_q <= cmd_data;
                        if (need_ri) begin
                            x_q     <= 1'b0;
                            state_q <= S_TO_RI;
                        end
                    end
                end
                S_ENTER: begin
                    sdo_q   <= data_q[0];
                    data_q  <= data_q >> 1;
                    x_q     <= (cnt_q != LEN_W'(1));
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    cap_q <= cap_q | (W'(sdi) << idx_q);
                    idx_q <= idx_q + LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        x_q     <= 1'b0;
                        sdo_q   <= 1'b0;
                        state_q <= S_EXIT;
                    end else begin
                        cnt_q  <= cnt_q - LEN_W'(1);
                        sdo_q  <= data_q[0];
                        data_q <= data_q >> 1;
                        x_q    <= (cnt_q != LEN_W'(2));
                    end
                end
                S_EXIT: begin
                    x_q     <= 1'b0;
                    rd_q    <= cap_q;
                    rv_q    <= 1'b1;
                    rdy_q   <= 1'b1;
                    state_q <= S_DONE;
                end
                S_WAIT: begin
                    if (cnt_q == LEN_W'(1)) begin
                        rd_q    <= '0;
                        rv_q    <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
                end
                S_RST_PATH: begin
                    // Steer by where the remote lands next: SH needs x=0, UP needs x=1, RS is done.
                    if (mstate_d == RS) begin
                        x_q     <= 1'b1;
                        rd_q    <= '0;
                        rv_q    <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        x_q <= (mstate_d == UP);
                    end
                end
                default: ;
            endcase

            if (dsp_en) begin
                cap_q  <= '0;
                idx_q  <= '0;
                cnt_q  <= d_len;
                data_q <= d_data;
                if (d_op == OP_RESET) begin
                    x_q     <= 1'b1;
                    state_q <= S_RST_PATH;
                end else if (d_op == OP_SHIFT && d_len != '0) begin
                    x_q     <= 1'b1;
                    state_q <= S_ENTER;
                end else if (d_op == OP_IDLE && d_len != '0) begin
                    x_q     <= 1'b0;
                    state_q <= S_WAIT;
                end else begin
                    rd_q    <= '0;
                    rv_q    <= 1'b1;
                    rdy_q   <= 1'b1;
                    state_q <= S_DONE;
                end
            end
        end
    end

    assign cmd_ready = rdy_q;
    assign x         = x_q;
    assign sdo       = sdo_q;
    assign rsp_valid = rv_q;
    assign rsp_data  = rd_q;
    assign mstate    = mstate_q;

endmodule

// File: tb/tb_scan_master.sv
// Scenario bench for scan_master: per-cycle traces of x/sdo/mstate plus a
// queue of expected response payloads.
module tb_scan_master;
    import scan_pkg::*;

    logic        clk = 1'b0;
    logic        rs_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_len = '0;
    logic [15:0] cmd_data = '0;
    logic        x, sdo, sdi, rsp_valid;
    logic [15:0] rsp_data;
    logic [3:0]  mstate;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    logic        x_tr  [0:63];
    logic        sdo_tr[0:63];
    logic [3:0]  ms_tr [0:63];

    logic [3:0] mdl_q, mdl_d;

    always #5 clk = ~clk;
    assign sdi = sdo;

    scan_master dut (
        .clk(clk), .rs_n(rs_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .x(x), .sdo(sdo),
        .sdi(sdi), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mstate(mstate)
    );

    // Independent remote FSM driven only by the x line.
    scan_mirror u_model (.state_i(mdl_q), .x_i(x), .next_o(mdl_d));
    always_ff @(posedge clk or negedge rs_n)
        if (!rs_n) mdl_q <= RS;
        else       mdl_q <= mdl_d;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic run(input logic [1:0] op, input logic [4:0] len, input logic [15:0] data,
                       output int ncyc, output logic [15:0] rdata);
        int w;
        ncyc = -1;
        rdata = 'x;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        w = 0;
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c < 64; c++) begin
            x_tr[c] = x; sdo_tr[c] = sdo; ms_tr[c] = mstate;
            if (rsp_valid) begin ncyc = c; rdata = rsp_data; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n; logic [15:0] rd, e;
        rs_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (mstate !== RS) begin bad++; $display("FAIL rst_mstate got=%b want=%b", mstate, RS); end
        total++; if (x !== 1'b1) begin bad++; $display("FAIL rst_x got=%b want=1", x); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_data !== 16'h0) begin bad++; $display("FAIL rst_rsp_data got=%h want=0000", rsp_data); end
        rs_n = 1'b1;
        exp_q.push_back(16'h0000);
        run(OP_IDLE, 5'd2, 16'h0, n, rd);
        e = exp_q.pop_front();
        total++; if (n !== 4) begin bad++; $display("FAIL idle_rs_cycles got=%0d want=4", n); end
        for (int c = 1; c <= 3; c++) begin
            total++; if (x_tr[c] !== 1'b0) begin bad++; $display("FAIL idle_rs_x[%0d] got=%b want=0", c, x_tr[c]); end
        end
        total++; if (ms_tr[4] !== RI) begin bad++; $display("FAIL idle_rs_mstate got=%b want=%b", ms_tr[4], RI); end
        total++; if (rd !== e) begin bad++; $display("FAIL idle_rs_data got=%h want=%h", rd, e); end
    endtask

    task automatic test_shift3();
        int n; logic [15:0] rd, e;
        logic [5:0] xe;
        logic [3:0] ms_e[1:6];
        xe = 6'b000111;
        ms_e[1] = RI; ms_e[2] = SH; ms_e[3] = SH; ms_e[4] = SH; ms_e[5] = UP; ms_e[6] = RI;
        exp_q.push_back(16'h0005);
        run(OP_SHIFT, 5'd3, 16'h0005, n, rd);
        e = exp_q.pop_front();
        total++; if (n !== 6) begin bad++; $display("FAIL sh3_cycles got=%0d want=6", n); end
        for (int c = 1; c <= 5; c++) begin
            total++; if (x_tr[c] !== xe[c-1]) begin bad++; $display("FAIL sh3_x[%0d] got=%b want=%b", c, x_tr[c], xe[c-1]); end
        end
        for (int c = 1; c <= 6; c++) begin
            total++; if (ms_tr[c] !== ms_e[c]) begin bad++; $display("FAIL sh3_ms[%0d] got=%b want=%b", c, ms_tr[c], ms_e[c]); end
        end
        total++; if (sdo_tr[2] !== 1'b1 || sdo_tr[3] !== 1'b0 || sdo_tr[4] !== 1'b1) begin
            bad++; $display("FAIL sh3_sdo got=%b%b%b want=101", sdo_tr[2], sdo_tr[3], sdo_tr[4]); end
        total++; if (rd !== e) begin bad++; $display("FAIL sh3_data got=%h want=%h", rd, e); end
    endtask

    task automatic test_shift_clamp();
        int n, shc; logic [15:0] rd, e;
        exp_q.push_back(16'hA5C3);
        run(OP_SHIFT, 5'd20, 16'hA5C3, n, rd);
        e = exp_q.pop_front();
        shc = 0;
        for (int c = 1; c <= n; c++) if (ms_tr[c] === SH) shc++;
        total++; if (shc !== 16) begin bad++; $display("FAIL clamp_sh_cycles got=%0d want=16", shc); end
        total++; if (n !== 19) begin bad++; $display("FAIL clamp_cycles got=%0d want=19", n); end
        total++; if (rd !== e) begin bad++; $display("FAIL clamp_data got=%h want=%h", rd, e); end
    endtask

    task automatic test_reset_cmd();
        int n; logic [15:0] rd, e;
        logic [3:0] ms_e[1:4];
        logic [2:0] xe;
        ms_e[1] = RI; ms_e[2] = SH; ms_e[3] = UP; ms_e[4] = RS;
        xe = 3'b101;
        exp_q.push_back(16'h0000);
        run(OP_RESET, 5'd0, 16'hFFFF, n, rd);
        e = exp_q.pop_front();
        total++; if (n !== 4) begin bad++; $display("FAIL rstcmd_cycles got=%0d want=4", n); end
        for (int c = 1; c <= 3; c++) begin
            total++; if (x_tr[c] !== xe[c-1]) begin bad++; $display("FAIL rstcmd_x[%0d] got=%b want=%b", c, x_tr[c], xe[c-1]); end
            total++; if (sdo_tr[c] !== 1'b0) begin bad++; $display("FAIL rstcmd_sdo[%0d] got=%b want=0", c, sdo_tr[c]); end
        end
        for (int c = 1; c <= 4; c++) begin
            total++; if (ms_tr[c] !== ms_e[c]) begin bad++; $display("FAIL rstcmd_ms[%0d] got=%b want=%b", c, ms_tr[c], ms_e[c]); end
        end
        total++; if (rd !== e) begin bad++; $display("FAIL rstcmd_data got=%h want=%h", rd, e); end
        @(negedge clk);
        total++; if (x !== 1'b1) begin bad++; $display("FAIL rstcmd_idle_x got=%b want=1", x); end
    endtask

    task automatic test_from_rs();
        int n; logic [15:0] rd, e;
        exp_q.push_back(16'h0000);
        run(OP_RSVD, 5'd7, 16'h1234, n, rd);
        e = exp_q.pop_front();
        total++; if (n !== 1) begin bad++; $display("FAIL rsvd_cycles got=%0d want=1", n); end
        total++; if (x_tr[1] !== 1'b1 || ms_tr[1] !== RS) begin bad++; $display("FAIL rsvd_hold got=%b/%b want=1/%b", x_tr[1], ms_tr[1], RS); end
        total++; if (rd !== e) begin bad++; $display("FAIL rsvd_data got=%h want=%h", rd, e); end
        exp_q.push_back(16'h0000);
        run(OP_RESET, 5'd0, 16'h0, n, rd);
        e = exp_q.pop_front();
        total++; if (n !== 2 || x_tr[1] !== 1'b1) begin bad++; $display("FAIL rst_from_rs got=%0d/%b want=2/1", n, x_tr[1]); end
        total++; if (rd !== e) begin bad++; $display("FAIL rst_from_rs_data got=%h want=%h", rd, e); end
        exp_q.push_back(16'h0000);
        run(OP_SHIFT, 5'd0, 16'hFFFF, n, rd);
        e = exp_q.pop_front();
        total++; if (n !== 2 || x_tr[1] !== 1'b0) begin bad++; $display("FAIL sh0_from_rs got=%0d/%b want=2/0", n, x_tr[1]); end
        total++; if (ms_tr[2] !== RI) begin bad++; $display("FAIL sh0_ms got=%b want=%b", ms_tr[2], RI); end
        total++; if (rd !== e) begin bad++; $display("FAIL sh0_data got=%h want=%h", rd, e); end
    endtask

    task automatic test_back_to_back();
        int c, busy_rdy; logic [15:0] e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_IDLE; cmd_len = 5'd3; cmd_data = 16'h0;
        exp_q.push_back(16'h0000);
        @(negedge clk);
        c = 1; busy_rdy = 0;
        while (!rsp_valid && c < 40) begin busy_rdy += int'(cmd_ready); @(negedge clk); c++; end
        e = exp_q.pop_front();
        total++; if (c !== 4) begin bad++; $display("FAIL b2b_first_cycles got=%0d want=4", c); end
        total++; if (busy_rdy !== 0) begin bad++; $display("FAIL b2b_busy_ready got=%0d want=0", busy_rdy); end
        total++; if (rsp_data !== e) begin bad++; $display("FAIL b2b_first_data got=%h want=%h", rsp_data, e); end
        cmd_op = OP_SHIFT; cmd_len = 5'd2; cmd_data = 16'h0002;
        exp_q.push_back(16'h0002);
        @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b want=0", cmd_ready); end
        cmd_valid = 1'b0;
        c = 1;
        while (!rsp_valid && c < 40) begin @(negedge clk); c++; end
        e = exp_q.pop_front();
        total++; if (c !== 5) begin bad++; $display("FAIL b2b_second_cycles got=%0d want=5", c); end
        total++; if (rsp_data !== e) begin bad++; $display("FAIL b2b_second_data got=%h want=%h", rsp_data, e); end
    endtask

    task automatic test_abort();
        int n, stray; logic [15:0] rd, e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SHIFT; cmd_len = 5'd8; cmd_data = 16'h00FF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (mstate !== SH) begin bad++; $display("FAIL abort_in_sh got=%b want=%b", mstate, SH); end
        rs_n = 1'b0;
        #1;
        total++; if (mstate !== RS || x !== 1'b1) begin bad++; $display("FAIL abort_state got=%b/%b want=%b/1", mstate, x, RS); end
        @(negedge clk);
        rs_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin stray += int'(rsp_valid); @(negedge clk); end
        total++; if (stray !== 0) begin bad++; $display("FAIL abort_rsp got=%0d want=0", stray); end
        exp_q.push_back(16'h0006);
        run(OP_SHIFT, 5'd4, 16'h0006, n, rd);
        e = exp_q.pop_front();
        total++; if (n !== 8) begin bad++; $display("FAIL after_abort_cycles got=%0d want=8", n); end
        total++; if (rd !== e) begin bad++; $display("FAIL after_abort_data got=%h want=%h", rd, e); end
    endtask

    task automatic test_mirror(input string tag);
        total++; if (mstate !== mdl_q) begin bad++; $display("FAIL mirror_%s got=%b want=%b", tag, mstate, mdl_q); end
    endtask

    initial begin
        test_reset();        test_mirror("reset");
        test_shift3();       test_mirror("shift3");
        test_shift_clamp();  test_mirror("clamp");
        test_reset_cmd();    test_mirror("rstcmd");
        test_from_rs();      test_mirror("from_rs");
        test_back_to_back(); test_mirror("b2b");
        test_abort();        test_mirror("abort");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
